// File: rtl/load_sched.sv
// Two-requester round-robin load-activity scheduler: grants bursts that rotate an activity pattern.
// Optional post-burst cooldown state enabled by defining LOAD_SCHED_COOLDOWN_EN.
module load_sched #(
    parameter int unsigned W        = 32,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned COOL_CYC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [CNT_W-1:0] len0,
    input  logic [CNT_W-1:0] len1,
    output logic [1:0]       gnt,
    output logic [1:0]       done,
    output logic             busy,
    output logic             load_out,
    output logic [31:0]      act_cnt
);

    // Alternating 1010 pattern with bit 0 clear, so load_out starts low.
    localparam logic [W-1:0] PAT_RST = W'({(W + 1) / 2{2'b10}});

`ifdef LOAD_SCHED_COOLDOWN_EN
    localparam int unsigned COOL_W = (COOL_CYC > 2) ? $clog2(COOL_CYC) : 1;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, COOL = 2'd2} state_t;
    localparam state_t LEAVE_ST = COOL;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1} state_t;
    localparam state_t LEAVE_ST = IDLE;
`endif

    if (COOL_CYC == 0) begin : g_cool_chk
        $error("load_sched: COOL_CYC must be at least 1");
    end

    state_t           state_q, state_nxt;
    logic             ptr_q, ptr_nxt;
    logic             own_q, own_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [W-1:0]     pat_q, pat_nxt;
    logic [1:0]       gnt_nxt, done_nxt;
    logic [31:0]      act_nxt;
    logic             busy_nxt;
    logic             win_c;
    logic [CNT_W-1:0] win_len_c;
    logic             own_req_c;
    logic             last_c;
`ifdef LOAD_SCHED_COOLDOWN_EN
    logic [COOL_W-1:0] cool_q, cool_nxt;
`endif

    // Tie goes to the requester not served last.
    always_comb begin
        win_c     = (req == 2'b11) ? ~ptr_q : req[1];
        win_len_c = win_c ? len1 : len0;
        own_req_c = req[own_q];
        last_c    = (cnt_q == CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: if ((|req) && (win_len_c != '0)) state_nxt = RUN;
            RUN:  if (!own_req_c || last_c) state_nxt = LEAVE_ST;
`ifdef LOAD_SCHED_COOLDOWN_EN
            COOL: if (cool_q == '0) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt_nxt  = gnt;
        done_nxt = '0;
        cnt_nxt  = cnt_q;
        ptr_nxt  = ptr_q;
        own_nxt  = own_q;
        pat_nxt  = pat_q;
        act_nxt  = act_cnt;
`ifdef LOAD_SCHED_COOLDOWN_EN
        cool_nxt = cool_q;
`endif
        case (state_q)
            IDLE: begin
                gnt_nxt = '0;
                if (|req) begin
                    ptr_nxt = win_c;
                    own_nxt = win_c;
                    if (win_len_c != '0) begin
                        gnt_nxt = 2'b01 << win_c;
                        cnt_nxt = win_len_c;
                    end else begin
                        done_nxt = 2'b01 << win_c;
                    end
                end
            end
            RUN: begin
`ifdef LOAD_SCHED_COOLDOWN_EN
                cool_nxt = COOL_W'(COOL_CYC - 1);
`endif
                if (own_req_c) begin
                    pat_nxt = {pat_q[0], pat_q[W-1:1]};
                    cnt_nxt = cnt_q - CNT_W'(1);
                    if (act_cnt != '1) act_nxt = act_cnt + 32'd1;
                    if (last_c) begin
                        gnt_nxt  = '0;
                        done_nxt = 2'b01 << own_q;
                    end
                end else begin
                    gnt_nxt = '0;
                end
            end
`ifdef LOAD_SCHED_COOLDOWN_EN
            COOL: begin
                gnt_nxt = '0;
                if (cool_q != '0) cool_nxt = cool_q - COOL_W'(1);
            end
`endif
            default: gnt_nxt = '0;
        endcase
        busy_nxt = (state_nxt != IDLE);
    end

    // Reset discards any burst or cooldown in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt     <= '0;
            done    <= '0;
            busy    <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= 1'b1;
            own_q   <= 1'b0;
            pat_q   <= PAT_RST;
            act_cnt <= '0;
`ifdef LOAD_SCHED_COOLDOWN_EN
            cool_q  <= '0;
`endif
        end else begin
            gnt     <= gnt_nxt;
            done    <= done_nxt;
            busy    <= busy_nxt;
            cnt_q   <= cnt_nxt;
            ptr_q   <= ptr_nxt;
            own_q   <= own_nxt;
            pat_q   <= pat_nxt;
            act_cnt <= act_nxt;
`ifdef LOAD_SCHED_COOLDOWN_EN
            cool_q  <= cool_nxt;
`endif
        end
    end

    assign load_out = pat_q[0];

endmodule
